// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed byte stream into big-endian words,
// writes them to instruction memory, verifies a checksum and releases the core.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LEN_HI = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] CSUM   = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    // Counter is one bit wider than the address so a full memory (N = 2^ADDR_W) fits.
    localparam int          CW    = ADDR_W + 1;
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    logic [2:0]    r_state;
    logic [7:0]    r_lenHi;
    logic [7:0]    r_sum;
    logic [CW-1:0] r_wordCnt;
    logic [CW-1:0] r_lastIdx;
    logic [1:0]    r_byteCnt;
    logic [23:0]   r_shift;

    logic          w_accept;
    logic [15:0]   w_len;
    logic [7:0]    w_nextSum;

    assign w_accept  = byte_valid && byte_ready;
    assign w_len     = {r_lenHi, byte_data};
    assign w_nextSum = r_sum + byte_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LEN_HI;
            r_lenHi    <= '0;
            r_sum      <= '0;
            r_wordCnt  <= '0;
            r_lastIdx  <= '0;
            r_byteCnt  <= '0;
            r_shift    <= '0;
            byte_ready <= 1'b1;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    LEN_HI: begin
                        r_lenHi <= byte_data;
                        r_state <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_lastIdx <= CW'(w_len - 16'd1);
                        if ({1'b0, w_len} > MAX_N) begin
                            r_state    <= ERR;
                            err        <= 1'b1;
                            byte_ready <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_sum     <= w_nextSum;
                        r_byteCnt <= r_byteCnt + 2'd1;
                        r_shift   <= {r_shift[15:0], byte_data};
                        // Fourth byte completes a word: strobe it out at this word's byte address.
                        if (r_byteCnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= {{(30 - CW){1'b0}}, r_wordCnt, 2'b00};
                            imem_wdata <= {r_shift, byte_data};
                            r_wordCnt  <= r_wordCnt + 1'b1;
                            if (r_wordCnt == r_lastIdx) begin
                                r_state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        byte_ready <= 1'b0;
                        if (byte_data == r_sum) begin
                            r_state <= RUN;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            err     <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a vector table for the nominal load plus
// directed sequences for error, boundary, gap and reset-abort cases.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   int weCount;
   logic [31:0] lastAddr;
   logic [31:0] lastData;
   logic readyDropped;

   typedef struct {
      logic        valid;
      logic [7:0]  data;
      logic        ready;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        cpuRst;
      logic        done;
      logic        err;
   } vec_t;

   vec_t vecs[12];

   localparam logic [68:0] RESET_OUTS = {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};

   imem_loader #(.ADDR_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .err        (err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends with a report.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [68:0] outs();
      return {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, done, err};
   endfunction

   // Drives one cycle of input, then samples outputs 1 ns after the edge and
   // records any write strobe seen.
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      @(negedge clk);
      byte_valid = v;
      byte_data  = d;
      @(posedge clk);
      #1;
      if (imem_we) begin
         weCount++;
         lastAddr = imem_waddr;
         lastData = imem_wdata;
      end
   endtask

   task automatic checkOutput(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      weCount  = 0;
      lastAddr = 32'h0;
      lastData = 32'h0;
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) applyStimulus(1'b1, w[i*8 +: 8]);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'h08, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h09, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 8'h0A, 1'b1, 1'b1, 32'h4, 32'h2009000A, 1'b1, 1'b0, 1'b0};
      // 0x20+0x08+0x00+0x05+0x20+0x09+0x00+0x0A = 0x60
      vecs[10] = '{1'b1, 8'h60, 1'b0, 1'b0, 32'h4, 32'h2009000A, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 32'h4, 32'h2009000A, 1'b0, 1'b1, 1'b0};

      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (2) @(posedge clk);
      doReset();
      checkOutput("reset_values", outs(), RESET_OUTS);

      // Nominal two-word load, one byte per cycle.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].data);
         checkOutput($sformatf("vec%0d", i), outs(),
                     {vecs[i].ready, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].cpuRst, vecs[i].done, vecs[i].err});
      end
      checkOutput("good_we_count", 69'(weCount), 69'(2));

      // Reset while running puts the core back in reset.
      doReset();
      checkOutput("rst_in_run", outs(), RESET_OUTS);

      // Same image, wrong checksum.
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h02);
      sendWord(32'h20080005);
      sendWord(32'h2009000A);
      applyStimulus(1'b1, 8'h57);
      checkOutput("badsum_outs", outs(), {1'b0, 1'b0, 32'h4, 32'h2009000A, 1'b1, 1'b0, 1'b1});
      checkOutput("badsum_we_count", 69'(weCount), 69'(2));
      applyStimulus(1'b1, 8'h60);
      checkOutput("err_sticky", outs(), {1'b0, 1'b0, 32'h4, 32'h2009000A, 1'b1, 1'b0, 1'b1});

      // Empty image.
      doReset();
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h00);
      checkOutput("n0_before_csum", outs(), RESET_OUTS);
      applyStimulus(1'b1, 8'h00);
      checkOutput("n0_done", outs(), {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      checkOutput("n0_we_count", 69'(weCount), 69'(0));

      // Length one past capacity.
      doReset();
      applyStimulus(1'b1, 8'h01);
      checkOutput("n257_after_hi", outs(), RESET_OUTS);
      applyStimulus(1'b1, 8'h01);
      checkOutput("n257_err", outs(), {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1});
      checkOutput("n257_we_count", 69'(weCount), 69'(0));

      // Full-capacity image of zeros.
      doReset();
      readyDropped = 1'b0;
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h00);
      for (int i = 0; i < 1024; i++) begin
         applyStimulus(1'b1, 8'h00);
         if (!byte_ready) readyDropped = 1'b1;
      end
      checkOutput("n256_ready_held", 69'(readyDropped), 69'(0));
      checkOutput("n256_we_count", 69'(weCount), 69'(256));
      checkOutput("n256_last_addr", 69'(lastAddr), 69'(32'h3FC));
      applyStimulus(1'b1, 8'h00);
      checkOutput("n256_done", outs(), {1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, 1'b1, 1'b0});

      // One word with random idle gaps; 0xDE+0xAD+0xBE+0xEF = 0x338 -> 0x38.
      doReset();
      readyDropped = 1'b0;
      begin
         logic [7:0] gapBytes[7];
         gapBytes = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
         for (int i = 0; i < 7; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
               applyStimulus(1'b0, 8'hA5);
               if (!byte_ready) readyDropped = 1'b1;
            end
            if (i == 6) checkOutput("gap_ready_held", 69'(readyDropped), 69'(0));
            applyStimulus(1'b1, gapBytes[i]);
            if (i < 6 && !byte_ready) readyDropped = 1'b1;
         end
      end
      checkOutput("gap_we_count", 69'(weCount), 69'(1));
      checkOutput("gap_word", {5'b0, lastAddr, lastData}, {5'b0, 32'h0, 32'hDEADBEEF});
      checkOutput("gap_done", outs(), {1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0});

      // Abort after the second byte of the second word, then a fresh one-word load.
      doReset();
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h02);
      sendWord(32'h11223344);
      applyStimulus(1'b1, 8'h55);
      applyStimulus(1'b1, 8'h66);
      doReset();
      checkOutput("abort_reset", outs(), RESET_OUTS);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h01);
      sendWord(32'hA1B2C3D4);
      checkOutput("abort_new_word", {5'b0, lastAddr, lastData}, {5'b0, 32'h0, 32'hA1B2C3D4});
      applyStimulus(1'b1, 8'hEA);
      checkOutput("abort_we_count", 69'(weCount), 69'(1));
      checkOutput("abort_done", outs(), {1'b0, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b1, 1'b0});

      // Reset coinciding with a word's fourth byte suppresses the write.
      doReset();
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h01);
      applyStimulus(1'b1, 8'h02);
      applyStimulus(1'b1, 8'h03);
      @(negedge clk);
      rst        = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h04;
      @(posedge clk);
      #1;
      checkOutput("rst_kills_write", outs(), RESET_OUTS);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
